// File: rtl/univ_counter_pkg.sv
// Shared types and constants for the universal modulo counter.
// Optional saturation is enabled by defining UNIV_MOD_COUNTER_SAT_EN.
package univ_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest counter the result struct can carry; instances cast down to N bits.
    localparam int MAX_N = 64;

    typedef struct packed {
        logic [MAX_N-1:0] value;
        logic             wrap;
        logic             sat_hit;
    } next_res_t;

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-value computation for a 0..mod_max modulo counter.
// Saturation branches exist only when UNIV_MOD_COUNTER_SAT_EN is defined.
module mod_step_calc
    import univ_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] step,
    input  logic [N-1:0] mod_max,
    input  logic         up,
`ifdef UNIV_MOD_COUNTER_SAT_EN
    input  logic         sat,
`endif
    output next_res_t    res
);

    logic [N-1:0] eff_step;
    logic [N-1:0] val;
    logic [N:0]   q_x;
    logic [N:0]   eff_x;
    logic [N:0]   mm_x;
    logic [N:0]   sum;
    logic [N:0]   lim;

    always_comb begin
        res      = '0;
        eff_step = (step < mod_max) ? step : mod_max;
        q_x      = {1'b0, q};
        eff_x    = {1'b0, eff_step};
        mm_x     = {1'b0, mod_max};
        sum      = q_x + eff_x;
        lim      = mm_x + 1'b1;
        val      = q;

        // A count left above a freshly lowered mod_max restarts at 0 without a wrap.
        if (q > mod_max) begin
            val = '0;
        end else if (eff_step != '0) begin
            if (up == DIR_UP) begin
                if (sum <= mm_x) begin
                    val = N'(sum);
                end else
`ifdef UNIV_MOD_COUNTER_SAT_EN
                if (sat) begin
                    val         = mod_max;
                    res.sat_hit = 1'b1;
                end else
`endif
                begin
                    val      = N'(sum - lim);
                    res.wrap = 1'b1;
                end
            end else begin
                if (q >= eff_step) begin
                    val = q - eff_step;
                end else
`ifdef UNIV_MOD_COUNTER_SAT_EN
                if (sat) begin
                    val         = '0;
                    res.sat_hit = 1'b1;
                end else
`endif
                begin
                    val      = N'(q_x + lim - eff_x);
                    res.wrap = 1'b1;
                end
            end
        end

        res.value = MAX_N'(val);
    end

endmodule

// File: rtl/univ_mod_counter.sv
// Universal up/down modulo counter with runtime terminal value, load and sticky overflow.
// Define UNIV_MOD_COUNTER_SAT_EN to add the sat input (saturate instead of wrap).
module univ_mod_counter
    import univ_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] step,
    input  logic [N-1:0] mod_max,
    input  logic [N-1:0] d,
    input  logic         ovf_clr,
`ifdef UNIV_MOD_COUNTER_SAT_EN
    input  logic         sat,
`endif
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap_tick,
    output logic         ovf_sticky
);

    next_res_t    res;
    logic [N-1:0] d_clip;
    logic         cnt_evt;

    mod_step_calc #(.N(N)) u_calc (
        .q       (q),
        .step    (step),
        .mod_max (mod_max),
        .up      (up),
`ifdef UNIV_MOD_COUNTER_SAT_EN
        .sat     (sat),
`endif
        .res     (res)
    );

    always_comb begin
        d_clip  = (d > mod_max) ? mod_max : d;
        cnt_evt = en && !syn_clr && !load && (res.wrap || res.sat_hit);
    end

    assign max_tick = (q == mod_max);
    assign min_tick = (q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= '0;
            wrap_tick  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            wrap_tick <= 1'b0;
            if (syn_clr) begin
                q <= '0;
            end else if (load) begin
                q <= d_clip;
            end else if (en) begin
                q         <= N'(res.value);
                wrap_tick <= res.wrap;
            end
            // Setting wins over a simultaneous clear request.
            if (cnt_evt)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_mod_counter.sv
// Self-checking bench for univ_mod_counter: directed literal cases plus randomized
// traffic compared each cycle against a modular-arithmetic reference model.
module tb_univ_mod_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         syn_clr, load, en, up, ovf_clr, sat;
    logic [N-1:0] step, mod_max, d;
    logic [N-1:0] q;
    logic         max_tick, min_tick, wrap_tick, ovf_sticky;

    int tests = 0;
    int fails = 0;

    int m_q, m_wrap, m_ovf;
    int mm_i, eff_i, st_i;
    bit ev;

    univ_mod_counter #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .syn_clr    (syn_clr),
        .load       (load),
        .en         (en),
        .up         (up),
        .step       (step),
        .mod_max    (mod_max),
        .d          (d),
        .ovf_clr    (ovf_clr),
`ifdef UNIV_MOD_COUNTER_SAT_EN
        .sat        (sat),
`endif
        .q          (q),
        .max_tick   (max_tick),
        .min_tick   (min_tick),
        .wrap_tick  (wrap_tick),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counting on the ring 0..mod_max using plain integer arithmetic.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q = 0; m_wrap = 0; m_ovf = 0;
        end else begin
            mm_i   = int'(mod_max);
            st_i   = int'(step);
            m_wrap = 0;
            ev     = 1'b0;
            if (syn_clr) begin
                m_q = 0;
            end else if (load) begin
                m_q = (int'(d) > mm_i) ? mm_i : int'(d);
            end else if (en) begin
                eff_i = (st_i < mm_i) ? st_i : mm_i;
                if (m_q > mm_i) begin
                    m_q = 0;
                end else if (eff_i != 0) begin
                    if (up) begin
                        if (m_q + eff_i > mm_i) begin
                            ev = 1'b1;
                            if (sat) m_q = mm_i;
                            else begin m_q = (m_q + eff_i) % (mm_i + 1); m_wrap = 1; end
                        end else m_q = m_q + eff_i;
                    end else begin
                        if (m_q < eff_i) begin
                            ev = 1'b1;
                            if (sat) m_q = 0;
                            else begin
                                m_q = (((m_q - eff_i) % (mm_i + 1)) + (mm_i + 1)) % (mm_i + 1);
                                m_wrap = 1;
                            end
                        end else m_q = m_q - eff_i;
                    end
                end
            end
            if (ev) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        check("q", int'(q), m_q);
        check("max_tick", int'(max_tick), int'(m_q == int'(mod_max)));
        check("min_tick", int'(min_tick), int'(m_q == 0));
        check("wrap_tick", int'(wrap_tick), m_wrap);
        check("ovf_sticky", int'(ovf_sticky), m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        syn_clr = 0; load = 0; en = 0; ovf_clr = 0; sat = 0;
    endtask

    initial begin : stim
        int exp_seq[12];
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        reset = 1; idle(); up = 1; step = 0; mod_max = 0; d = 0;
        repeat (2) tick();
        check("rst_q", int'(q), 0);
        check("rst_wrap", int'(wrap_tick), 0);
        check("rst_ovf", int'(ovf_sticky), 0);
        reset = 0;

        // Up count 0..9 with wrap
        mod_max = 9; step = 1; up = 1; en = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_seq_q", int'(q), exp_seq[i]);
            check("up_seq_wrap", int'(wrap_tick), int'(exp_seq[i] == 0));
        end
        check("up_seq_ovf", int'(ovf_sticky), 1);
        idle();

        // Down wrap from 2 by 5
        load = 1; d = 2; tick(); idle();
        en = 1; up = 0; step = 5; tick();
        check("dn_wrap_q", int'(q), 7);
        check("dn_wrap_tick", int'(wrap_tick), 1);
        tick();
        check("dn_next_q", int'(q), 2);
        check("dn_next_tick", int'(wrap_tick), 0);
        idle();

        // Load clipping and clear priority
        mod_max = 99; load = 1; d = 200; tick();
        check("load_clip_q", int'(q), 99);
        check("load_clip_max", int'(max_tick), 1);
        syn_clr = 1; tick();
        check("clr_over_load", int'(q), 0);
        idle();

        // mod_max lowered below q
        load = 1; d = 50; tick(); idle();
        mod_max = 20; en = 1; up = 1; step = 1; tick();
        check("shrink_q", int'(q), 0);
        check("shrink_wrap", int'(wrap_tick), 0);
        idle();
        ovf_clr = 1; tick();
        check("ovf_clr", int'(ovf_sticky), 0);
        idle();
        mod_max = 9; load = 1; d = 9; tick(); idle();
        en = 1; ovf_clr = 1; tick();
        check("set_wins_q", int'(q), 0);
        check("set_wins_ovf", int'(ovf_sticky), 1);
        idle();

        // mod_max = 0 holds at 0
        mod_max = 0; en = 1; step = 3; up = 1;
        repeat (3) tick();
        check("mm0_q", int'(q), 0);
        check("mm0_max", int'(max_tick), 1);
        check("mm0_min", int'(min_tick), 1);
        idle();

        // Asynchronous reset mid-count
        mod_max = 9; step = 1; up = 1; en = 1;
        repeat (4) tick();
        #2 reset = 1;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_wrap", int'(wrap_tick), 0);
        check("arst_ovf", int'(ovf_sticky), 0);
        reset = 0;
        tick();
        check("arst_resume", int'(q), 1);
        idle();

`ifdef UNIV_MOD_COUNTER_SAT_EN
        ovf_clr = 1; tick(); idle();
        mod_max = 15; load = 1; d = 14; tick(); idle();
        sat = 1; en = 1; up = 1; step = 3; tick();
        check("sat_up_q", int'(q), 15);
        check("sat_up_wrap", int'(wrap_tick), 0);
        check("sat_up_ovf", int'(ovf_sticky), 1);
        idle();
        load = 1; d = 1; tick(); idle();
        sat = 1; en = 1; up = 0; step = 3; tick();
        check("sat_dn_q", int'(q), 0);
        idle();
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            syn_clr = ($urandom_range(0, 19) == 0);
            load    = ($urandom_range(0, 9) == 0);
            en      = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            up      = $urandom_range(0, 1);
`ifdef UNIV_MOD_COUNTER_SAT_EN
            sat     = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 15) == 0)
                mod_max = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            step = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            d    = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
